// File: rtl/demux_1_4.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1_4
//  Purpose  : 1:4 word de-serializer. Collects four consecutive valid words
//             from a serialized lane and presents them together as one frame
//             (slot 0 -> out_1 ... slot 3 -> out_4). A sync strobe realigns
//             the frame, and a mid-frame sync raises a one-cycle error pulse.
//             A wrapping counter tracks completed frames.
//  Ports    : clock        - rising-edge clock
//             reset        - asynchronous, active-low reset
//             in_data      - serialized data word (WIDTH bits)
//             in_valid     - in_data carries a word this cycle
//             in_sync      - with in_valid, current word is slot 0
//             out_1..out_4 - slot 0..3 words of the last completed frame
//             out_valid    - pulse: out_1..out_4 updated at previous edge
//             frame_err    - pulse: mid-frame sync dropped a partial frame
//             frame_count  - completed frames, wraps modulo 2^FCNT_W
//  Revision : 1.0 - initial release
// ============================================================================
module demux_1_4 #(
    parameter int WIDTH  = 16,
    parameter int FCNT_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    input  logic              in_sync,
    output logic [WIDTH-1:0]  out_1,
    output logic [WIDTH-1:0]  out_2,
    output logic [WIDTH-1:0]  out_3,
    output logic [WIDTH-1:0]  out_4,
    output logic              out_valid,
    output logic              frame_err,
    output logic [FCNT_W-1:0] frame_count
);

    // Slot positions within a frame.
    localparam logic [1:0] c_SLOT0 = 2'd0;
    localparam logic [1:0] c_SLOT1 = 2'd1;
    localparam logic [1:0] c_SLOT2 = 2'd2;
    localparam logic [1:0] c_SLOT3 = 2'd3;

    logic [1:0]        r_slot_q,  w_slot_d;
    logic [WIDTH-1:0]  r_sh0_q,   w_sh0_d;
    logic [WIDTH-1:0]  r_sh1_q,   w_sh1_d;
    logic [WIDTH-1:0]  r_sh2_q,   w_sh2_d;
    logic [WIDTH-1:0]  r_out1_q,  w_out1_d;
    logic [WIDTH-1:0]  r_out2_q,  w_out2_d;
    logic [WIDTH-1:0]  r_out3_q,  w_out3_d;
    logic [WIDTH-1:0]  r_out4_q,  w_out4_d;
    logic              r_valid_q, w_valid_d;
    logic              r_err_q,   w_err_d;
    logic [FCNT_W-1:0] r_fcnt_q,  w_fcnt_d;
    logic [1:0]        w_eff_slot;

    always_comb begin
        // Everything holds by default; the two pulses fall back to 0.
        w_slot_d   = r_slot_q;
        w_sh0_d    = r_sh0_q;
        w_sh1_d    = r_sh1_q;
        w_sh2_d    = r_sh2_q;
        w_out1_d   = r_out1_q;
        w_out2_d   = r_out2_q;
        w_out3_d   = r_out3_q;
        w_out4_d   = r_out4_q;
        w_valid_d  = 1'b0;
        w_err_d    = 1'b0;
        w_fcnt_d   = r_fcnt_q;
        // Sync overrides the running position and restarts the frame.
        w_eff_slot = in_sync ? c_SLOT0 : r_slot_q;

        if (in_valid) begin
            // A sync that lands anywhere but slot 0 abandons a partial frame.
            // Stale sh1/sh2 are harmless: they are rewritten before slot 3.
            w_err_d = in_sync && (r_slot_q != c_SLOT0);
            case (w_eff_slot)
                c_SLOT0: begin
                    w_sh0_d  = in_data;
                    w_slot_d = c_SLOT1;
                end
                c_SLOT1: begin
                    w_sh1_d  = in_data;
                    w_slot_d = c_SLOT2;
                end
                c_SLOT2: begin
                    w_sh2_d  = in_data;
                    w_slot_d = c_SLOT3;
                end
                default: begin
                    // Slot 3: the whole frame is published in one edge so the
                    // outputs are never seen partially updated.
                    w_out1_d  = r_sh0_q;
                    w_out2_d  = r_sh1_q;
                    w_out3_d  = r_sh2_q;
                    w_out4_d  = in_data;
                    w_valid_d = 1'b1;
                    w_fcnt_d  = r_fcnt_q + 1'b1;
                    w_slot_d  = c_SLOT0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_slot_q  <= c_SLOT0;
            r_sh0_q   <= '0;
            r_sh1_q   <= '0;
            r_sh2_q   <= '0;
            r_out1_q  <= '0;
            r_out2_q  <= '0;
            r_out3_q  <= '0;
            r_out4_q  <= '0;
            r_valid_q <= 1'b0;
            r_err_q   <= 1'b0;
            r_fcnt_q  <= '0;
        end else begin
            r_slot_q  <= w_slot_d;
            r_sh0_q   <= w_sh0_d;
            r_sh1_q   <= w_sh1_d;
            r_sh2_q   <= w_sh2_d;
            r_out1_q  <= w_out1_d;
            r_out2_q  <= w_out2_d;
            r_out3_q  <= w_out3_d;
            r_out4_q  <= w_out4_d;
            r_valid_q <= w_valid_d;
            r_err_q   <= w_err_d;
            r_fcnt_q  <= w_fcnt_d;
        end
    end

    assign out_1       = r_out1_q;
    assign out_2       = r_out2_q;
    assign out_3       = r_out3_q;
    assign out_4       = r_out4_q;
    assign out_valid   = r_valid_q;
    assign frame_err   = r_err_q;
    assign frame_count = r_fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_1_4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1_4
//  Purpose  : Self-checking bench for demux_1_4: vector table, directed
//             corner sequences and random traffic against a frame-level
//             reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1_4;

    localparam int WIDTH  = 16;
    localparam int FCNT_W = 8;
    localparam int SNAP_W = 4 * WIDTH + 2 + FCNT_W;

    logic              clock;
    logic              reset;
    logic [WIDTH-1:0]  in_data;
    logic              in_valid;
    logic              in_sync;
    logic [WIDTH-1:0]  out_1, out_2, out_3, out_4;
    logic              out_valid;
    logic              frame_err;
    logic [FCNT_W-1:0] frame_count;

    demux_1_4 #(.WIDTH(WIDTH), .FCNT_W(FCNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sync     (in_sync),
        .out_1       (out_1),
        .out_2       (out_2),
        .out_3       (out_3),
        .out_4       (out_4),
        .out_valid   (out_valid),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Frame-level reference: the words of the frame in progress are kept in
    // a queue; four of them make a frame.
    logic [WIDTH-1:0]  m_q[$];
    logic [WIDTH-1:0]  m_out[4];
    logic              m_valid;
    logic              m_err;
    logic [FCNT_W-1:0] m_cnt;

    typedef struct {
        logic [WIDTH-1:0]  d;
        logic              v;
        logic              s;
        logic [WIDTH-1:0]  o1, o2, o3, o4;
        logic              ov;
        logic              oe;
        logic [FCNT_W-1:0] cnt;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic [WIDTH-1:0] d, input logic v, input logic s,
                                input logic [WIDTH-1:0] o1, input logic [WIDTH-1:0] o2,
                                input logic [WIDTH-1:0] o3, input logic [WIDTH-1:0] o4,
                                input logic ov, input logic oe, input logic [FCNT_W-1:0] cnt);
        vec_t r;
        r.d = d; r.v = v; r.s = s;
        r.o1 = o1; r.o2 = o2; r.o3 = o3; r.o4 = o4;
        r.ov = ov; r.oe = oe; r.cnt = cnt;
        return r;
    endfunction

    function automatic logic [SNAP_W-1:0] dut_snap();
        return {out_1, out_2, out_3, out_4, out_valid, frame_err, frame_count};
    endfunction

    function automatic logic [SNAP_W-1:0] model_snap();
        return {m_out[0], m_out[1], m_out[2], m_out[3], m_valid, m_err, m_cnt};
    endfunction

    task automatic chk(input string name, input logic [SNAP_W-1:0] act, input logic [SNAP_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_cnt   = '0;
    endtask

    // Drive one cycle, advance the model at the edge, compare 1 time unit later.
    task automatic step(input logic [WIDTH-1:0] d, input logic v, input logic s, input string name);
        in_data  = d;
        in_valid = v;
        in_sync  = s;
        @(posedge clock);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (v) begin
            if (s) begin
                m_err = (m_q.size() != 0);
                m_q.delete();
            end
            m_q.push_back(d);
            if (m_q.size() == 4) begin
                for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
                m_valid = 1'b1;
                m_cnt++;
                m_q.delete();
            end
        end
        #1;
        chk(name, dut_snap(), model_snap());
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", dut_snap(), '0);
        reset = 1'b1;
    endtask

    int pulses;

    initial begin
        // Test 1 (plain frame), then realignment and sync corner cases.
        tbl[0]  = mk(16'h0011, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 8'd0);
        tbl[1]  = mk(16'h0022, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 8'd0);
        tbl[2]  = mk(16'h0033, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 8'd0);
        tbl[3]  = mk(16'h0044, 1, 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 1, 0, 8'd1);
        tbl[4]  = mk(16'h0000, 0, 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, 0, 8'd1);
        tbl[5]  = mk(16'hA000, 1, 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, 0, 8'd1);
        tbl[6]  = mk(16'hA001, 1, 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, 0, 8'd1);
        tbl[7]  = mk(16'hB000, 1, 1, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, 1, 8'd1);
        tbl[8]  = mk(16'hB001, 1, 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, 0, 8'd1);
        tbl[9]  = mk(16'hB002, 1, 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, 0, 8'd1);
        tbl[10] = mk(16'hB003, 1, 0, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 1, 0, 8'd2);
        tbl[11] = mk(16'h0000, 0, 0, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 0, 0, 8'd2);
        tbl[12] = mk(16'h1234, 0, 1, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 0, 0, 8'd2);
        tbl[13] = mk(16'hC000, 1, 1, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 0, 0, 8'd2);
        tbl[14] = mk(16'hC001, 1, 0, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 0, 0, 8'd2);
        tbl[15] = mk(16'hC002, 1, 0, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 0, 0, 8'd2);
        tbl[16] = mk(16'hC003, 1, 0, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 1, 0, 8'd3);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].d, tbl[i].v, tbl[i].s, $sformatf("model_tbl%0d", i));
            chk($sformatf("table%0d", i), dut_snap(),
                {tbl[i].o1, tbl[i].o2, tbl[i].o3, tbl[i].o4, tbl[i].ov, tbl[i].oe, tbl[i].cnt});
        end

        // Gaps inside a frame delay completion but do not change the result.
        do_reset();
        step(16'h0011, 1, 0, "gap_w0");
        step(16'h0022, 1, 0, "gap_w1");
        step(16'h0000, 0, 0, "gap_idle0");
        step(16'h0000, 0, 0, "gap_idle1");
        step(16'h0033, 1, 0, "gap_w2");
        chk("gap_pre", dut_snap(), '0);
        step(16'h0044, 1, 0, "gap_w3");
        chk("gap_done", dut_snap(), {16'h0011, 16'h0022, 16'h0033, 16'h0044, 1'b1, 1'b0, 8'd1});

        // Continuous stream: completion every 4th word with no bubble.
        do_reset();
        for (int i = 1; i <= 12; i++) step(WIDTH'(i), 1, 0, $sformatf("stream%0d", i));
        chk("stream_end", dut_snap(), {16'h0009, 16'h000A, 16'h000B, 16'h000C, 1'b1, 1'b0, 8'd3});

        // Reset asserted between edges mid-frame clears immediately.
        step(16'h0D00, 1, 0, "midrst_w0");
        step(16'h0D01, 1, 0, "midrst_w1");
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("async_reset", dut_snap(), '0);
        model_reset();
        #2;
        reset = 1'b1;
        step(16'h1111, 1, 0, "realign_w0");
        step(16'h2222, 1, 0, "realign_w1");
        step(16'h3333, 1, 0, "realign_w2");
        step(16'h4444, 1, 0, "realign_w3");
        chk("realign", dut_snap(), {16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1, 1'b0, 8'd1});

        // 256 frames bring the counter back to zero.
        do_reset();
        pulses = 0;
        for (int f = 0; f < 256; f++) begin
            for (int w = 0; w < 4; w++) begin
                step(WIDTH'(f * 4 + w), 1, 0, "wrap");
                if (out_valid) pulses++;
            end
        end
        chk("wrap_count", {{(SNAP_W-FCNT_W){1'b0}}, frame_count}, '0);
        chk("wrap_pulses", SNAP_W'(pulses), SNAP_W'(256));

        // Random traffic with gaps and occasional syncs.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step(WIDTH'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
